// File: rtl/airlock_pressure_seq.sv
// Airlock pressure sequencer: times chamber fill and vent, enforces the door
// interlock, supports abort of a fill and holds a latched fault until cleared.
// Optional build macro AIRLOCK_SETTLE_EN adds a valves-closed settle phase
// after each fill/vent before the chamber status is reported.
module airlock_pressure_seq #(
  parameter int unsigned FILL_CYCLES   = 8,
  parameter int unsigned VENT_CYCLES   = 5,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic begin_fill,
  input  logic begin_vent,
  input  logic abort,
  input  logic clear_fault,
  input  logic InnerClosed,
  input  logic OuterClosed,
  output logic FillValve,
  output logic VentValve,
  output logic Pressurized,
  output logic Evacuated,
  output logic Busy,
  output logic Rejected,
  output logic Fault
);

  // StSettle is only reachable when AIRLOCK_SETTLE_EN is defined.
  typedef enum logic [2:0] {StIdle, StFill, StVent, StSettle, StFault} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_last;
  logic             pressurized_q, pressurized_d;
  logic             evacuated_q, evacuated_d;
  logic             rejected_q, rejected_d;
  logic             fill_valve_q, vent_valve_q, busy_q, fault_q;
  logic             doors, timer_done;
`ifdef AIRLOCK_SETTLE_EN
  logic             after_fill_q, after_fill_d;
`endif

  assign doors = InnerClosed & OuterClosed;

  // Terminal count for the phase currently being timed.
  always_comb begin
    timer_last = CNT_W'(FILL_CYCLES - 1);
    case (state_q)
      StVent:   timer_last = CNT_W'(VENT_CYCLES - 1);
      StSettle: timer_last = CNT_W'(SETTLE_CYCLES - 1);
      default:  timer_last = CNT_W'(FILL_CYCLES - 1);
    endcase
  end

  assign timer_done = (timer_q == timer_last);

  // Next-state, timer and chamber-status logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pressurized_d = pressurized_q;
    evacuated_d   = evacuated_q;
    rejected_d    = 1'b0;
`ifdef AIRLOCK_SETTLE_EN
    after_fill_d  = after_fill_q;
`endif
    case (state_q)
      StIdle: begin
        if (begin_fill && begin_vent) begin
          rejected_d = 1'b1;
        end else if ((begin_fill || begin_vent) && !doors) begin
          rejected_d = 1'b1;
        end else if (begin_fill && evacuated_q) begin
          state_d       = StFill;
          timer_d       = '0;
          pressurized_d = 1'b0;
          evacuated_d   = 1'b0;
        end else if (begin_vent && pressurized_q) begin
          state_d       = StVent;
          timer_d       = '0;
          pressurized_d = 1'b0;
          evacuated_d   = 1'b0;
        end
      end
      StFill, StVent: begin
        // Door fault outranks abort and completion.
        if (!doors) begin
          state_d       = StFault;
          timer_d       = '0;
          pressurized_d = 1'b0;
          evacuated_d   = 1'b0;
        end else if (abort && (state_q == StFill)) begin
          state_d = StVent;
          timer_d = '0;
        end else if (timer_done) begin
          timer_d = '0;
`ifdef AIRLOCK_SETTLE_EN
          state_d      = StSettle;
          after_fill_d = (state_q == StFill);
`else
          state_d       = StIdle;
          pressurized_d = (state_q == StFill);
          evacuated_d   = (state_q == StVent);
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSettle: begin
`ifdef AIRLOCK_SETTLE_EN
        if (!doors) begin
          state_d       = StFault;
          timer_d       = '0;
          pressurized_d = 1'b0;
          evacuated_d   = 1'b0;
        end else if (abort && after_fill_q) begin
          state_d = StVent;
          timer_d = '0;
        end else if (timer_done) begin
          state_d       = StIdle;
          timer_d       = '0;
          pressurized_d = after_fill_q;
          evacuated_d   = !after_fill_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`else
        state_d = StIdle;
        timer_d = '0;
`endif
      end
      StFault: begin
        if (clear_fault && doors) begin
          state_d = StVent;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // State, timer and registered outputs; valves follow the next state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      pressurized_q <= 1'b0;
      evacuated_q   <= 1'b1;
      rejected_q    <= 1'b0;
      fill_valve_q  <= 1'b0;
      vent_valve_q  <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pressurized_q <= pressurized_d;
      evacuated_q   <= evacuated_d;
      rejected_q    <= rejected_d;
      fill_valve_q  <= (state_d == StFill);
      vent_valve_q  <= (state_d == StVent);
      busy_q        <= (state_d == StFill) || (state_d == StVent) || (state_d == StSettle);
      fault_q       <= (state_d == StFault);
    end
  end

`ifdef AIRLOCK_SETTLE_EN
  // Remembers which operation a settle phase follows.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      after_fill_q <= 1'b0;
    end else begin
      after_fill_q <= after_fill_d;
    end
  end
`endif

  assign FillValve   = fill_valve_q;
  assign VentValve   = vent_valve_q;
  assign Pressurized = pressurized_q;
  assign Evacuated   = evacuated_q;
  assign Busy        = busy_q;
  assign Rejected    = rejected_q;
  assign Fault       = fault_q;

endmodule

// File: doc/airlock_pressure_seq.md
Name: airlock_pressure_seq

Overview:
- Parametrised successor to the single-bit fill/pressurize stage of the airlock controller.
- Sequences both chamber pressurization (fill) and evacuation (vent) with cycle-count timers.
- Handles door-interlock checking, abort, and a latched fault state.
- Sits between the top-level airlock FSM (issues requests) and the valve drivers / status LEDs.

Parameters:
- FILL_CYCLES, 8: clock cycles FillValve is held high to reach pressurized; legal range >= 1.
- VENT_CYCLES, 5: clock cycles VentValve is held high to reach evacuated; legal range >= 1.
- SETTLE_CYCLES, 3: settle duration; used only with SETTLE_EN; legal range >= 1.
- CNT_W, 8: timer width; must hold max(FILL_CYCLES, VENT_CYCLES, SETTLE_CYCLES) - 1.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- begin_fill  in  1  level request to pressurize.
- begin_vent  in  1  level request to evacuate.
- abort  in  1  abandon the current fill.
- clear_fault  in  1  leave the FAULT state.
- InnerClosed  in  1  1 = inner door closed.
- OuterClosed  in  1  1 = outer door closed.
- FillValve  out  1  registered fill valve drive.
- VentValve  out  1  registered vent valve drive.
- Pressurized  out  1  chamber at pressure.
- Evacuated  out  1  chamber evacuated.
- Busy  out  1  high in any state other than IDLE or FAULT.
- Rejected  out  1  one-cycle pulse when a request is refused.
- Fault  out  1  high while in FAULT.

Behaviour:
- Reset (asynchronous, Reset=0):
  - state=IDLE, timer=0.
  - Evacuated=1; Pressurized, FillValve, VentValve, Busy, Rejected, Fault all 0.
- All outputs are registered; doors = InnerClosed & OuterClosed.
- States: IDLE, FILL, VENT, SETTLE (SETTLE_EN only), FAULT.
- IDLE:
  - begin_fill & !begin_vent & doors & Evacuated -> FILL, timer=0.
  - begin_vent & !begin_fill & doors & Pressurized -> VENT, timer=0.
  - Any request while !doors -> stay IDLE, Rejected=1 for one cycle.
  - begin_fill & begin_vent together -> stay IDLE, Rejected=1 for one cycle.
  - A request that is already satisfied (e.g. fill while Pressurized) -> no action, no Rejected.
- FILL:
  - FillValve=1; Pressurized=0; Evacuated=0; timer increments each cycle.
  - When timer==FILL_CYCLES-1 -> IDLE, Pressurized=1, FillValve=0.
  - FillValve is therefore high for exactly FILL_CYCLES cycles.
- VENT:
  - Same as FILL with VentValve and VENT_CYCLES.
  - Completion sets Evacuated=1.
- Abort:
  - abort in FILL -> VENT with timer=0 on the next edge; the chamber is re-evacuated.
  - abort in IDLE or VENT is ignored.
- Door interlock:
  - !doors in FILL, VENT or SETTLE -> FAULT on the next edge.
  - Both valves go to 0; Pressurized=0, Evacuated=0.
  - Door fault has priority over abort and over timer completion in the same cycle.
- FAULT:
  - Fault=1, valves 0.
  - clear_fault & doors -> VENT, timer=0.
  - clear_fault while !doors is ignored.
- Timer wrap: cannot occur; the timer is cleared on every state entry.
- Reset mid-operation returns immediately to the reset values; valves drop asynchronously.

Optional Feature:
- Macro: AIRLOCK_SETTLE_EN.
- Defined:
  - FILL and VENT completion enter SETTLE with both valves 0 for SETTLE_CYCLES cycles, Busy=1, status flags 0.
  - On exit to IDLE, set Pressurized or Evacuated according to the preceding operation.
  - abort in a post-fill SETTLE -> VENT.
  - A door opening in SETTLE -> FAULT.
- Undefined:
  - No SETTLE state; completion goes directly to IDLE as described above.
  - SETTLE_CYCLES is unused.

Test Plan:
- Reset deasserted, doors closed, begin_fill=1 for 1 cycle, FILL_CYCLES=8 -> FillValve high exactly 8 cycles, then Pressurized=1, Evacuated=0, Busy=0.
- From Pressurized, begin_vent with VENT_CYCLES=5 -> VentValve high 5 cycles, then Evacuated=1.
- begin_fill with OuterClosed=0 -> Rejected pulses once, state stays IDLE, Evacuated stays 1.
- Fill running, InnerClosed drops at timer=3 -> next edge Fault=1, FillValve=0, both flags 0.
  - Then clear_fault with doors open -> remains FAULT.
  - Then close doors + clear_fault -> VENT for 5 cycles -> Evacuated=1.
- Fill at timer=4, abort=1 -> VentValve high 5 cycles, Pressurized never set, ends Evacuated=1.
- With AIRLOCK_SETTLE_EN, SETTLE_CYCLES=3: fill -> 8 cycles FillValve, 3 cycles both valves low with Busy=1, then Pressurized=1.
  - Also: Reset pulsed mid-FILL -> outputs return to the reset values immediately.
